// File: rtl/maze_pkg.sv
// Shared constants and types for the maze router SRAM subsystem.
package maze_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned SramDepth    = 256;

  // One-hot so the grant outputs are direct state bits.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StOwn0 = 3'b010,
    StOwn1 = 3'b100
  } arb_state_e;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter for the shared map/result SRAM, with lock and
// a bounded burst so a locked owner hands over once the other side has waited long enough.
module sram_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] mem_din
);

  localparam int unsigned CntW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;  // 1: requester 1 owned last
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;

  logic            acc0, acc1;
  logic [CntW-1:0] cnt_inc;
  logic            cap_hit;

  assign r0_gnt    = (state_q == StOwn0);
  assign r1_gnt    = (state_q == StOwn1);
  assign acc0      = r0_req & r0_gnt;
  assign acc1      = r1_req & r1_gnt;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rvalid0_q ? mem_din : '0;
  assign r1_rdata  = rvalid1_q ? mem_din : '0;

  // Saturating count; with an unlimited burst the counter never moves.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign cap_hit = (MAX_BURST != 0) && (cnt_inc == CntMax);

  always_comb begin
    mem_cs   = acc0 | acc1;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    if (acc0) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_dout = r0_wdata;
    end else if (acc1) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_dout = r1_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    rvalid0_d = acc0 & ~r0_we;
    rvalid1_d = acc1 & ~r1_we;
    unique case (state_q)
      StIdle: begin
        if (r0_req && (!r1_req || last_q)) begin
          state_d = StOwn0;
        end else if (r1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!r0_req && !r0_lock) begin
          state_d = r1_req ? StOwn1 : StIdle;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (acc0 && cap_hit && r1_req) begin
          state_d = StOwn1;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (acc0) begin
          cnt_d = cnt_inc;
        end
      end
      StOwn1: begin
        if (!r1_req && !r1_lock) begin
          state_d = r0_req ? StOwn0 : StIdle;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (acc1 && cap_hit && r0_req) begin
          state_d = StOwn0;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (acc1) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a capped (16) and an unlimited (0) instance share stimulus and
// are compared every cycle against an ownership-level model, plus literal spot checks.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

  logic [1:0]      g0, g1, rv0o, rv1o, cs, we;
  logic [1:0][7:0] rd0, rd1, addr, dout, din;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(16)) u_dut_cap (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(g0[0]), .r0_rvalid(rv0o[0]), .r0_rdata(rd0[0]),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(g1[0]), .r1_rvalid(rv1o[0]), .r1_rdata(rd1[0]),
    .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_dout(dout[0]),
    .mem_din(din[0])
  );

  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_BURST(0)) u_dut_unl (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(g0[1]), .r0_rvalid(rv0o[1]), .r0_rdata(rd0[1]),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(g1[1]), .r1_rvalid(rv1o[1]), .r1_rdata(rd1[1]),
    .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_dout(dout[1]),
    .mem_din(din[1])
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h80) ? 8'h05 : (a ^ 8'h3c);
  endfunction

  // SRAM macros driven by the DUTs.
  logic [7:0] sram [2][256];
  bit         sram_w [2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k]) begin
        if (we[k]) begin
          sram[k][addr[k]]   <= dout[k];
          sram_w[k][addr[k]] <= 1'b1;
        end else begin
          din[k] <= sram_w[k][addr[k]] ? sram[k][addr[k]] : init_val(addr[k]);
        end
      end
    end
  end

  // Model: owner is -1 (none), 0 or 1; cnt counts accesses in the current ownership.
  int         caps [2] = '{16, 0};
  int         owner [2], last [2], cnt [2];
  bit         mrv0 [2], mrv1 [2];
  logic [7:0] mrd0 [2], mrd1 [2];
  logic [7:0] mm [2][256];
  bit         mw [2][256];

  function automatic bit req_of(input int o);
    return (o == 0) ? r0_req : r1_req;
  endfunction
  function automatic bit we_of(input int o);
    return (o == 0) ? r0_we : r1_we;
  endfunction
  function automatic bit lock_of(input int o);
    return (o == 0) ? r0_lock : r1_lock;
  endfunction
  function automatic logic [7:0] addr_of(input int o);
    return (o == 0) ? r0_addr : r1_addr;
  endfunction
  function automatic logic [7:0] wd_of(input int o);
    return (o == 0) ? r0_wdata : r1_wdata;
  endfunction

  int         m_o, m_oth, m_new;
  bit         m_acc, m_rel;
  logic [7:0] m_a, m_rd;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        owner[k] = -1; last[k] = 1; cnt[k] = 0; mrv0[k] = 0; mrv1[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_o   = owner[k];
        m_acc = (m_o >= 0) && req_of(m_o);
        mrv0[k] = 0;
        mrv1[k] = 0;
        if (m_acc) begin
          m_a = addr_of(m_o);
          if (we_of(m_o)) begin
            mm[k][m_a] = wd_of(m_o);
            mw[k][m_a] = 1;
          end else begin
            m_rd = mw[k][m_a] ? mm[k][m_a] : init_val(m_a);
            if (m_o == 0) begin mrv0[k] = 1; mrd0[k] = m_rd; end
            else begin mrv1[k] = 1; mrd1[k] = m_rd; end
          end
        end
        if (m_o < 0) begin
          if (r0_req && r1_req) owner[k] = (last[k] == 0) ? 1 : 0;
          else if (r0_req) owner[k] = 0;
          else if (r1_req) owner[k] = 1;
        end else begin
          m_oth = 1 - m_o;
          m_rel = !req_of(m_o) && !lock_of(m_o);
          m_new = cnt[k] + (m_acc ? 1 : 0);
          if (caps[k] > 0 && m_new > caps[k]) m_new = caps[k];
          if (m_rel || (caps[k] > 0 && m_acc && m_new == caps[k] && req_of(m_oth))) begin
            owner[k] = (m_rel && !req_of(m_oth)) ? -1 : m_oth;
            last[k]  = m_o;
            cnt[k]   = 0;
          end else begin
            cnt[k] = m_new;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  int         c_o;
  bit         c_acc;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      c_o   = owner[k];
      c_acc = (c_o >= 0) && req_of(c_o);
      chk($sformatf("r0_gnt[%0d]", k), 32'(g0[k]), 32'(c_o == 0));
      chk($sformatf("r1_gnt[%0d]", k), 32'(g1[k]), 32'(c_o == 1));
      chk($sformatf("mem_cs[%0d]", k), 32'(cs[k]), 32'(c_acc));
      chk($sformatf("mem_we[%0d]", k), 32'(we[k]), c_acc ? 32'(we_of(c_o)) : 32'd0);
      chk($sformatf("mem_addr[%0d]", k), 32'(addr[k]), c_acc ? 32'(addr_of(c_o)) : 32'd0);
      chk($sformatf("mem_dout[%0d]", k), 32'(dout[k]), c_acc ? 32'(wd_of(c_o)) : 32'd0);
      chk($sformatf("r0_rvalid[%0d]", k), 32'(rv0o[k]), 32'(mrv0[k]));
      chk($sformatf("r1_rvalid[%0d]", k), 32'(rv1o[k]), 32'(mrv1[k]));
      chk($sformatf("r0_rdata[%0d]", k), 32'(rd0[k]), mrv0[k] ? 32'(mrd0[k]) : 32'd0);
      chk($sformatf("r1_rdata[%0d]", k), 32'(rd1[k]), mrv1[k] ? 32'(mrd1[k]) : 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n_acc;

  initial begin
    reset = 1'b0;
    r0_req = 1'b1; r0_we = 1'b0; r0_lock = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
    r1_req = 1'b1; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
    step(3);
    chk("reset_gnt0", 32'(g0[0]), 32'd0);
    chk("reset_cs", 32'(cs[0]), 32'd0);
    chk("reset_rvalid", 32'(rv0o[0]), 32'd0);
    reset = 1'b1;

    // Tie from IDLE after reset goes to r0; release hands over directly.
    step(1);
    chk("tie_r0_gnt", 32'(g0[0]), 32'd1);
    chk("tie_r1_wait", 32'(g1[0]), 32'd0);
    r0_req = 1'b0;
    step(1);
    chk("handover_r1", 32'(g1[0]), 32'd1);
    r1_addr = 8'h80;
    step(1);
    chk("read_rvalid1", 32'(rv1o[0]), 32'd1);
    chk("read_rdata1", 32'(rd1[0]), 32'h05);
    chk("read_rvalid0", 32'(rv0o[0]), 32'd0);
    r1_req = 1'b0;
    r0_req = 1'b1;
    step(1);
    chk("alternate_r0", 32'(g0[0]), 32'd1);
    r0_req = 1'b0;
    step(2);

    // Locked r0 writes with gaps while r1 waits.
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b1; r0_addr = 8'h10; r0_wdata = 8'h11;
    step(1);
    r1_req = 1'b1;
    n_acc = 0;
    for (int c = 0; n_acc < 16 && c < 64; c++) begin
      r0_req   = (c % 4 != 3);
      r0_addr  = 8'(c);
      r0_wdata = 8'(c) ^ 8'h5a;
      if (r0_req) n_acc++;
      step(1);
      if (n_acc < 16) chk("lock_hold", 32'(g0[0]), 32'd1);
    end
    chk("cap_handover", 32'(g1[0]), 32'd1);
    chk("cap_release0", 32'(g0[0]), 32'd0);
    chk("unl_keeps", 32'(g0[1]), 32'd1);

    // r1 locked now; the count restarts so r0 gets it back after 16 r1 accesses.
    r0_req = 1'b1;
    r1_lock = 1'b1;
    step(15);
    chk("cnt_restart_hold", 32'(g1[0]), 32'd1);
    step(1);
    chk("cnt_restart_back", 32'(g0[0]), 32'd1);

    for (int i = 0; i < 100; i++) begin
      r0_addr  = 8'(i);
      r0_wdata = ~8'(i);
      step(1);
      chk("unl_starve", 32'(g1[1]), 32'd0);
    end
    r0_req = 1'b0; r0_lock = 1'b0;
    step(1);
    chk("unl_release", 32'(g1[1]), 32'd1);

    // Read in flight when reset hits is dropped.
    r1_req = 1'b0; r1_lock = 1'b0; r0_we = 1'b0;
    step(3);
    r0_req = 1'b1; r0_addr = 8'h80;
    step(1);
    chk("mid_gnt_before", 32'(g0[0]), 32'd1);
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rvalid", 32'(rv0o[0]), 32'd0);
    chk("mid_gnt", 32'(g0[0]), 32'd0);
    chk("mid_cs", 32'(cs[0]), 32'd0);
    r0_req = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
